pp_bank_buffer: RTL

- Single-clock, N-bank ping-pong buffer; successor to the two-bank dual-FIFO design.
- Writer fills one bank while the reader drains previously sealed banks in order, oldest first.
- Bank width, depth, bank count and flip threshold are parametrised.
- Adds per-bank fill length, stall/overflow detection, read-valid handshake and flip counting.
- Sits between the sample acquisition path and the host readout path.

---
 rtl/pp_bank_pkg.sv | 25 ++
 rtl/pp_bank_ram.sv | 28 ++
 rtl/pp_bank_buffer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pp_bank_pkg.sv
// Shared types and width helpers for the N-bank ping-pong buffer.
package pp_bank_pkg;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_BANK_DEPTH = 1024;
  localparam int unsigned DEF_NUM_BANKS  = 2;
  localparam int unsigned DEF_BANK_W     = $clog2(DEF_NUM_BANKS);
  localparam int unsigned DEF_PTR_W      = $clog2(DEF_BANK_DEPTH);

  typedef enum logic [1:0] {
    BANK_FREE,
    BANK_FILL,
    BANK_SEALED
  } bank_state_e;

  typedef enum logic {
    WR_FILL,
    WR_STALL
  } wr_state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pp_bank_ram.sv
// Simple dual-port single-clock RAM with registered, enable-held read data.
module pp_bank_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2048,
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pp_bank_buffer.sv
// N-bank ping-pong buffer: writer fills one bank while sealed banks drain oldest first.
// Optional PP_LAST_FLAG_EN adds data_last / data_bank read-side tags.
module pp_bank_buffer
  import pp_bank_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned BANK_DEPTH  = DEF_BANK_DEPTH,
  parameter int unsigned NUM_BANKS   = DEF_NUM_BANKS,
  parameter int unsigned FLIP_THRESH = BANK_DEPTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [DATA_W-1:0]                data_in,
  input  logic                             force_flip,
  output logic                             full,
  output logic                             overflow,
  input  logic                             rd_en,
  output logic [DATA_W-1:0]                data_out,
  output logic                             data_valid,
  output logic                             empty,
  output logic [$clog2(NUM_BANKS+1)-1:0]   banks_ready,
  output logic [15:0]                      flip_cnt
`ifdef PP_LAST_FLAG_EN
  ,
  output logic                             data_last,
  output logic [idx_w(NUM_BANKS)-1:0]      data_bank
`endif
);

  localparam int unsigned BW = idx_w(NUM_BANKS);
  localparam int unsigned PW = $clog2(BANK_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned RW = $clog2(NUM_BANKS + 1);
  localparam int unsigned AW = BW + PW;
  localparam logic [CW-1:0] THRESH    = CW'(FLIP_THRESH);
  localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS - 1);

  bank_state_e       bank_st  [NUM_BANKS];
  logic [CW-1:0]     bank_len [NUM_BANKS];
  wr_state_e         wr_state, wr_state_nx;
  logic [BW-1:0]     wr_bank, rd_bank, wr_bank_nx, rd_bank_nx;
  logic [CW-1:0]     wr_cnt, post_cnt;
  logic [PW-1:0]     rd_ptr;
  logic              wr_fire, seal, rd_fire, rd_last, drain;

  assign wr_bank_nx = (wr_bank == LAST_BANK) ? '0 : wr_bank + 1'b1;
  assign rd_bank_nx = (rd_bank == LAST_BANK) ? '0 : rd_bank + 1'b1;
  assign full       = (wr_state == WR_STALL);
  assign empty      = (banks_ready == '0);
  assign rd_fire    = rd_en && !empty;
  assign rd_last    = (({1'b0, rd_ptr} + CW'(1)) == bank_len[rd_bank]);
  assign drain      = rd_fire && rd_last;

  // The seal test uses the post-write count so a same-cycle write lands in the sealed bank.
  always_comb begin
    wr_state_nx = wr_state;
    wr_fire     = 1'b0;
    seal        = 1'b0;
    post_cnt    = wr_cnt;
    case (wr_state)
      WR_FILL: begin
        wr_fire  = wr_en;
        post_cnt = wr_cnt + CW'(wr_en);
        seal     = (post_cnt == THRESH) || (force_flip && (post_cnt != '0));
        if (seal && (bank_st[wr_bank_nx] != BANK_FREE)) wr_state_nx = WR_STALL;
      end
      WR_STALL: begin
        if (bank_st[wr_bank] == BANK_FREE) wr_state_nx = WR_FILL;
      end
      default: wr_state_nx = WR_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) wr_state <= WR_FILL;
    else     wr_state <= wr_state_nx;
  end

  // Bank-state updates from the seal and drain paths never target the same bank in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_BANKS; i++) begin
        bank_st[i]  <= (i == 0) ? BANK_FILL : BANK_FREE;
        bank_len[i] <= '0;
      end
      wr_bank     <= '0;
      rd_bank     <= '0;
      wr_cnt      <= '0;
      rd_ptr      <= '0;
      overflow    <= 1'b0;
      flip_cnt    <= '0;
      banks_ready <= '0;
      data_valid  <= 1'b0;
    end else begin
      if (wr_fire) wr_cnt <= post_cnt;
      if (seal) begin
        bank_len[wr_bank] <= post_cnt;
        bank_st[wr_bank]  <= BANK_SEALED;
        wr_bank           <= wr_bank_nx;
        wr_cnt            <= '0;
        flip_cnt          <= flip_cnt + 16'd1;
        if (bank_st[wr_bank_nx] == BANK_FREE) bank_st[wr_bank_nx] <= BANK_FILL;
      end
      if (full && (bank_st[wr_bank] == BANK_FREE)) bank_st[wr_bank] <= BANK_FILL;
      if (full && wr_en) overflow <= 1'b1;

      if (rd_fire) begin
        if (rd_last) begin
          bank_st[rd_bank] <= BANK_FREE;
          rd_ptr           <= '0;
          rd_bank          <= rd_bank_nx;
        end else begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
      data_valid <= rd_fire;

      if (seal && !drain)      banks_ready <= banks_ready + RW'(1);
      else if (!seal && drain) banks_ready <= banks_ready - RW'(1);
    end
  end

`ifdef PP_LAST_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      data_last <= 1'b0;
      data_bank <= '0;
    end else begin
      data_last <= drain;
      if (rd_fire) data_bank <= rd_bank;
    end
  end
`endif

  pp_bank_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (NUM_BANKS * BANK_DEPTH),
    .ADDR_W (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_fire),
    .wr_addr ({wr_bank, wr_cnt[PW-1:0]}),
    .wr_data (data_in),
    .rd_en   (rd_fire),
    .rd_addr ({rd_bank, rd_ptr}),
    .rd_data (data_out)
  );

endmodule
